// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and the control-word field positions used by the decoder.
package muldiv_pkg;

  // Operation encodings on the op input
  localparam logic [1:0] MULDIV_OP_MULT  = 2'd0;
  localparam logic [1:0] MULDIV_OP_MULTU = 2'd1;
  localparam logic [1:0] MULDIV_OP_DIV   = 2'd2;
  localparam logic [1:0] MULDIV_OP_DIVU  = 2'd3;

  // Control-word field indices the control unit uses to drive this block
  localparam int MULDIV_CTRL_START  = 0;
  localparam int MULDIV_CTRL_OP_LSB = 1;
  localparam int MULDIV_CTRL_OP_MSB = 2;
  localparam int MULDIV_CTRL_HI_WE  = 3;
  localparam int MULDIV_CTRL_LO_WE  = 4;
  localparam int MULDIV_CTRL_W      = 5;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } muldiv_state_e;

  // True for the signed flavours (MULT, DIV): op bit 0 clear
  function automatic logic op_is_signed(input logic [1:0] op_v);
    return ~op_v[0];
  endfunction

  // True for the divide flavours (DIV, DIVU): op bit 1 set
  function automatic logic op_is_div(input logic [1:0] op_v);
    return op_v[1];
  endfunction

endpackage

// File: rtl/muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Multiply is shift-add, divide is restoring; both run on operand magnitudes
// in one shared 2*WIDTH accumulator and a sign fix-up is applied at the end.
module muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2 = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  muldiv_state_e    state_q;
  logic [CW-1:0]    cnt_q;
  logic [W2-1:0]    acc_q;
  logic [W2-1:0]    acc_d;
  logic [WIDTH-1:0] opb_q;      // multiplicand / divisor magnitude
  logic [WIDTH-1:0] a_q;        // original dividend, returned as HI on divide by zero
  logic [1:0]       op_q;
  logic             neg_q;      // product / quotient must be negated
  logic             rneg_q;     // remainder must be negated
  logic             dz_q;       // divisor was zero
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH:0]   div_trial_s;
  logic [W2-1:0]    prod_s;
  logic [WIDTH-1:0] quo_s;
  logic [WIDTH-1:0] rem_s;
  logic [WIDTH-1:0] fix_hi_s;
  logic [WIDTH-1:0] fix_lo_s;

  // Two's-complement magnitude when the operation is signed
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  // One multiply or divide iteration on the shared accumulator
  always_comb begin
    mul_sum_s   = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, opb_q};
    div_trial_s = acc_q[W2-1:WIDTH-1] - {1'b0, opb_q};
    acc_d       = acc_q;
    if (op_is_div(op_q)) begin
      if (!div_trial_s[WIDTH]) begin
        acc_d = {div_trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {acc_q[W2-2:0], 1'b0};
      end
    end else begin
      if (acc_q[0]) begin
        acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
      end else begin
        acc_d = {1'b0, acc_q[W2-1:1]};
      end
    end
  end

  // Sign correction and special cases applied when the result is written
  always_comb begin
    prod_s   = neg_q ? (~acc_q + W2'(1)) : acc_q;
    quo_s    = neg_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    rem_s    = rneg_q ? (~acc_q[W2-1:WIDTH] + WIDTH'(1)) : acc_q[W2-1:WIDTH];
    fix_hi_s = prod_s[W2-1:WIDTH];
    fix_lo_s = prod_s[WIDTH-1:0];
    if (op_is_div(op_q)) begin
      if (dz_q) begin
        fix_hi_s = a_q;
        fix_lo_s = {WIDTH{1'b1}};
      end else begin
        fix_hi_s = rem_s;
        fix_lo_s = quo_s;
      end
    end else begin
      fix_hi_s = prod_s[W2-1:WIDTH];
      fix_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // Sequencer: latch operands in IDLE, iterate in CALC, write HI/LO in FIX
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opb_q   <= '0;
      a_q     <= '0;
      op_q    <= 2'd0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            op_q    <= op;
            acc_q   <= {{WIDTH{1'b0}}, mag(a, op_is_signed(op))};
            opb_q   <= mag(b, op_is_signed(op));
            a_q     <= a;
            neg_q   <= op_is_signed(op) & (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_q  <= op_is_signed(op) & a[WIDTH-1];
            dz_q    <= (b == '0);
            cnt_q   <= CW'(WIDTH - 1);
            busy_q  <= 1'b1;
            state_q <= ST_CALC;
          end else begin
            if (hi_we) begin
              hi_q <= wdata;
            end
            if (lo_we) begin
              lo_q <= wdata;
            end
          end
        end
        ST_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          hi_q    <= fix_hi_s;
          lo_q    <= fix_lo_s;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: expected HI/LO pairs are queued when an
// operation is issued and compared when the done pulse appears.
module tb_muldiv;
  import muldiv_pkg::*;

  logic        clk;
  logic        clr_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  logic [63:0] sb_q[$];
  int          n_checks;
  int          n_fail;

  muldiv #(.WIDTH(32)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, wait for done, compare against the queued result
  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic [63:0] exp, input bit inj, input bit with_we);
    int n;
    int bcnt;
    int dcnt;
    logic [63:0] e;
    sb_q.push_back(exp);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    hi_we = with_we; lo_we = with_we; wdata = 32'h5555_5555;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom_range(3, 0));
    n = 0;
    bcnt = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy === 1'b1) bcnt++;
      start = 1'b0; lo_we = 1'b0;
      if (inj && n == 4) begin
        start = 1'b1; op = MULDIV_OP_DIV; a = 32'd99; b = 32'd3;
      end
      if (inj && n == 5) begin
        lo_we = 1'b1; wdata = 32'h0000_AAAA;
      end
      n++;
      @(negedge clk);
    end
    start = 1'b0; lo_we = 1'b0;
    check("latency", 64'(n), 64'd33);
    check("busy_cycles", 64'(bcnt), 64'd33);
    check("busy_at_done", {63'd0, busy}, 64'd0);
    e = sb_q.pop_front();
    check("hi", {32'd0, hi}, {32'd0, e[63:32]});
    check("lo", {32'd0, lo}, {32'd0, e[31:0]});
    dcnt = 0;
    repeat (inj ? 40 : 1) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    check("extra_done", 64'(dcnt), 64'd0);
  endtask

  initial begin
    int dcnt;
    n_checks = 0;
    n_fail   = 0;
    clr_n = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    clr_n = 1'b1;
    @(negedge clk);

    run_op(MULDIV_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 1'b0);
    run_op(MULDIV_OP_MULT,  32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b0);
    run_op(MULDIV_OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 1'b0);
    run_op(MULDIV_OP_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0);
    run_op(MULDIV_OP_DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0, 1'b0);
    run_op(MULDIV_OP_DIVU,  32'd100,       32'd7,         64'h0000_0002_0000_000E, 1'b0, 1'b1);
    run_op(MULDIV_OP_DIVU,  32'hFFFF_FFFF, 32'h10,        64'h0000_000F_0FFF_FFFF, 1'b0, 1'b0);
    run_op(MULDIV_OP_DIV,   32'h1234,      32'd0,         64'h0000_1234_FFFF_FFFF, 1'b0, 1'b0);
    run_op(MULDIV_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 1'b0);
    run_op(MULDIV_OP_MULTU, 32'd5,         32'd6,         64'h0000_0000_0000_001E, 1'b1, 1'b0);

    // MTHI in IDLE, then abort a multiply with reset
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_we = 1'b0;
    check("mthi_hi", {32'd0, hi}, 64'h0000_0000_DEAD_BEEF);
    check("mthi_lo", {32'd0, lo}, 64'h0000_0000_0000_001E);
    check("mthi_done", {63'd0, done}, 64'd0);
    start = 1'b1; op = MULDIV_OP_MULT; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    check("abort_busy_pre", {63'd0, busy}, 64'd1);
    repeat (9) @(negedge clk);
    clr_n = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    clr_n = 1'b1;
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
    end
    check("abort_no_done", 64'(dcnt), 64'd0);
    check("abort_hilo_after", {hi, lo}, 64'd0);
    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
